// File: rtl/pc_sel_ctrl.sv
// pc_sel_ctrl: next-PC source sequencer for the RV32IC pipeline.
// Picks between PC+4, PC+2, the branch/jump target and hold. It also
// sequences the post-redirect squash window and the halt drain, and
// counts redirects in a saturating counter for performance debug.
module pc_sel_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             is_compressed,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             halt,
    output logic [1:0]       pc_sel,
    output logic             pc_write,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_count
);

    // Stop elaboration if a parameter is outside the range the 3-bit counter supports
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("pc_sel_ctrl: FLUSH_CYCLES must be in 1..7");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain
        $error("pc_sel_ctrl: DRAIN_CYCLES must be in 1..7");
    end

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_PC2    = 2'b01;
    localparam logic [1:0] SEL_TARGET = 2'b10;
    localparam logic [1:0] SEL_HOLD   = 2'b11;

    // The detection cycle is the first flush cycle, so the squash window is one shorter
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_SQUASH,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_next;
    logic             r_halted;
    logic [CNT_W-1:0] r_redirect_count;
    logic             w_redir;
    logic             w_take_redir;
    logic [1:0]       w_seq_sel;

    assign w_redir   = branch_taken | jump;
    assign w_seq_sel = is_compressed ? SEL_PC2 : SEL_PC4;

    // Next-state and Mealy outputs; a taken redirect overrides the per-state choice
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        pc_sel       = SEL_HOLD;
        pc_write     = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        w_take_redir = 1'b0;

        case (r_state)
            S_INIT: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_redir) begin
                    w_take_redir = 1'b1;
                end else if (halt) begin
                    flush_if_id  = 1'b1;
                    w_cnt_next   = DRAIN_RELOAD;
                    w_state_next = S_DRAIN;
                end else if (!stall) begin
                    pc_sel   = w_seq_sel;
                    pc_write = 1'b1;
                end
            end
            S_SQUASH: begin
                // Everything decoded here comes from squashed bubbles
                pc_sel      = w_seq_sel;
                pc_write    = 1'b1;
                flush_id_ex = 1'b1;
                w_cnt_next  = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                flush_if_id = 1'b1;
                if (w_redir) begin
                    // An older branch/jump still in flight cancels the halt
                    w_take_redir = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_next = S_HALTED;
                    end
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase

        if (w_take_redir) begin
            pc_sel      = SEL_TARGET;
            pc_write    = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (FLUSH_CYCLES == 1) begin
                w_cnt_next   = 3'd0;
                w_state_next = S_RUN;
            end else begin
                w_cnt_next   = FLUSH_RELOAD;
                w_state_next = S_SQUASH;
            end
        end

        // During reset hold the PC and clear both pipeline registers
        if (rst) begin
            pc_sel       = SEL_HOLD;
            pc_write     = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            w_take_redir = 1'b0;
        end
    end

    // State, counter, halted flag and saturating redirect counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_INIT;
            r_cnt            <= 3'd0;
            r_halted         <= 1'b0;
            r_redirect_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_halted <= (w_state_next == S_HALTED);
            if (w_take_redir && (r_redirect_count != {CNT_W{1'b1}})) begin
                r_redirect_count <= r_redirect_count + 1'b1;
            end
        end
    end

    assign halted         = r_halted;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// tb_pc_sel_ctrl: directed, table-driven bench for pc_sel_ctrl.
// A second instance with CNT_W=2 shares the stimulus so that counter
// saturation can be observed.
module tb_pc_sel_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        is_compressed;
    logic        branch_taken;
    logic        jump;
    logic        halt;
    logic [1:0]  pc_sel;
    logic        pc_write;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic [15:0] redirect_count;
    logic [1:0]  pc_sel2;
    logic        pc_write2;
    logic        flush_if_id2;
    logic        flush_id_ex2;
    logic        halted2;
    logic [1:0]  redirect_count2;

    int errors = 0;
    int checks = 0;

    pc_sel_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .is_compressed  (is_compressed),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .halt           (halt),
        .pc_sel         (pc_sel),
        .pc_write       (pc_write),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .halted         (halted),
        .redirect_count (redirect_count)
    );

    pc_sel_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(2)) u_dut_sat (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .is_compressed  (is_compressed),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .halt           (halt),
        .pc_sel         (pc_sel2),
        .pc_write       (pc_write2),
        .flush_if_id    (flush_if_id2),
        .flush_id_ex    (flush_id_ex2),
        .halted         (halted2),
        .redirect_count (redirect_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       s;
        logic       c;
        logic       b;
        logic       j;
        logic       h;
        logic [1:0] sel;
        logic       pw;
        logic       fif;
        logic       fie;
        logic       hl;
        int         cnt;
        int         cnt2;
    } vec_t;

    function automatic vec_t mk(input logic r, s, c, b, j, h,
                                input logic [1:0] sel, input logic pw, fif, fie, hl,
                                input int cnt, input int cnt2);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.b = b; v.j = j; v.h = h;
        v.sel = sel; v.pw = pw; v.fif = fif; v.fie = fie; v.hl = hl;
        v.cnt = cnt; v.cnt2 = cnt2;
        return v;
    endfunction

    // One cycle: drive inputs just after the edge, compare mid-cycle, advance
    task automatic step(input logic r, s, c, b, j, h,
                        input logic [1:0] esel, input logic epw, efif, efie, ehl,
                        input int ecnt, input int ecnt2, input string name);
        logic [21:0] act1, exp1;
        logic [7:0]  act2, exp2;
        rst = r; stall = s; is_compressed = c; branch_taken = b; jump = j; halt = h;
        #4;
        exp1 = {esel, epw, efif, efie, ehl, 16'(ecnt)};
        act1 = {pc_sel, pc_write, flush_if_id, flush_id_ex, halted, redirect_count};
        exp2 = {esel, epw, efif, efie, ehl, 2'(ecnt2)};
        act2 = {pc_sel2, pc_write2, flush_if_id2, flush_id_ex2, halted2, redirect_count2};
        checks++;
        if (act1 !== exp1) begin
            errors++;
            $display("FAIL %s: got sel/pw/fif/fie/halted/cnt=%h required %h", name, act1, exp1);
        end else begin
            $display("ok   %s: sel=%b pw=%b fif=%b fie=%b halted=%b cnt=%0d",
                     name, pc_sel, pc_write, flush_if_id, flush_id_ex, halted, redirect_count);
        end
        checks++;
        if (act2 !== exp2) begin
            errors++;
            $display("FAIL %s_sat: got sel/pw/fif/fie/halted/cnt=%h required %h", name, act2, exp2);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];

    initial begin
        // Reset, INIT, compressed sequencing, redirect squash, stall vs redirect
        vecs[0]  = mk(1,0,0,0,0,0, 2'b11,0,1,1,0, 0,0);
        vecs[1]  = mk(1,0,0,0,0,0, 2'b11,0,1,1,0, 0,0);
        vecs[2]  = mk(0,0,0,0,0,0, 2'b11,0,0,0,0, 0,0);  // INIT
        vecs[3]  = mk(0,0,0,0,0,0, 2'b00,1,0,0,0, 0,0);
        vecs[4]  = mk(0,0,1,0,0,0, 2'b01,1,0,0,0, 0,0);
        vecs[5]  = mk(0,0,0,0,0,0, 2'b00,1,0,0,0, 0,0);
        vecs[6]  = mk(0,0,1,0,0,0, 2'b01,1,0,0,0, 0,0);
        vecs[7]  = mk(0,0,0,1,0,0, 2'b10,1,1,1,0, 0,0);  // branch taken
        vecs[8]  = mk(0,0,0,0,1,0, 2'b00,1,0,1,0, 1,1);  // squash, jump ignored
        vecs[9]  = mk(0,0,0,0,0,0, 2'b00,1,0,0,0, 1,1);  // back in RUN
        vecs[10] = mk(0,1,0,0,1,0, 2'b10,1,1,1,0, 1,1);  // jump beats stall
        vecs[11] = mk(0,1,1,0,0,0, 2'b01,1,0,1,0, 2,2);  // stall masked in squash
        vecs[12] = mk(0,1,0,0,0,0, 2'b11,0,0,0,0, 2,2);  // stalled
        vecs[13] = mk(0,1,1,0,0,0, 2'b11,0,0,0,0, 2,2);  // stalled
        vecs[14] = mk(0,0,0,0,0,0, 2'b00,1,0,0,0, 2,2);

        rst = 1'b1; stall = 1'b0; is_compressed = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].c, vecs[i].b, vecs[i].j, vecs[i].h,
                 vecs[i].sel, vecs[i].pw, vecs[i].fif, vecs[i].fie, vecs[i].hl,
                 vecs[i].cnt, vecs[i].cnt2, $sformatf("vec%0d", i));
        end

        // Halt drain: detection cycle, three drain cycles, then halted for good
        step(0,1,0,0,0,1, 2'b11,0,1,0,0, 2,2, "halt_detect");
        step(0,0,0,0,0,0, 2'b11,0,1,0,0, 2,2, "drain1");
        step(0,1,0,0,0,1, 2'b11,0,1,0,0, 2,2, "drain2");
        step(0,0,1,0,0,0, 2'b11,0,1,0,0, 2,2, "drain3");
        step(0,0,0,1,0,0, 2'b11,0,0,0,1, 2,2, "halted_br");
        step(0,1,0,0,1,1, 2'b11,0,0,0,1, 2,2, "halted_jmp");
        step(0,0,1,1,1,0, 2'b11,0,0,0,1, 2,2, "halted_both");
        step(1,0,0,0,0,0, 2'b11,0,1,1,1, 2,2, "halted_rst");
        step(0,0,0,0,0,0, 2'b11,0,0,0,0, 0,0, "reinit");
        step(0,0,0,0,0,0, 2'b00,1,0,0,0, 0,0, "rerun");

        // Halt cancelled by an older branch in the second drain cycle
        step(0,0,0,0,0,1, 2'b11,0,1,0,0, 0,0, "halt2_detect");
        step(0,0,0,0,0,0, 2'b11,0,1,0,0, 0,0, "halt2_drain1");
        step(0,0,0,1,0,0, 2'b10,1,1,1,0, 0,0, "halt2_cancel");
        step(0,0,0,0,0,0, 2'b00,1,0,1,0, 1,1, "cancel_squash");
        step(0,0,1,0,0,0, 2'b01,1,0,0,0, 1,1, "cancel_run");

        // Four more redirects: 5 total, the 2-bit counter holds at 3
        for (int k = 0; k < 4; k++) begin
            step(0,0,0,1,(k == 1),0, 2'b10,1,1,1,0, 1 + k, (1 + k > 3) ? 3 : 1 + k,
                 $sformatf("sat_redir%0d", k));
            step(0,0,0,0,0,0, 2'b00,1,0,1,0, 2 + k, (2 + k > 3) ? 3 : 2 + k,
                 $sformatf("sat_squash%0d", k));
        end
        step(0,0,0,0,0,0, 2'b00,1,0,0,0, 5,3, "sat_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sel_ctrl.md
Name: pc_sel_ctrl

Overview:
- Sequencer for the 32-bit 4:1 next-PC multiplexer in the pipelined RV32IC core.
- Every cycle it chooses the next PC source and drives PC write enable and pipeline flush strobes:
  - sequential +4 or +2 (compressed instruction)
  - branch/jump target
  - hold
- Handles redirect squash windows, load-use stalls and halt drain (ecall/ebreak), and keeps a saturating redirect counter for performance debug.

Parameters:
- FLUSH_CYCLES, 2, total cycles flush_id_ex is asserted per redirect, detection cycle included; legal range 1..7.
- DRAIN_CYCLES, 3, cycles to drain older instructions after halt before halted rises; legal range 1..7.
- CNT_W, 16, width of redirect_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hazard-unit stall request (load-use).
- is_compressed  in  1  instruction in IF is 16-bit.
- branch_taken  in  1  EX-stage branch resolved taken.
- jump  in  1  EX-stage JAL/JALR.
- halt  in  1  ID-stage ecall/ebreak decoded.
- pc_sel  out  2  next-PC mux select: 00 = PC+4, 01 = PC+2, 10 = target, 11 = hold current PC.
- pc_write  out  1  PC register enable.
- flush_if_id  out  1  zero the IF/ID register.
- flush_id_ex  out  1  zero the ID/EX register.
- halted  out  1  core stopped.
- redirect_count  out  CNT_W  number of redirects taken, saturating.

Behaviour:
- States: INIT, RUN, SQUASH, DRAIN, HALTED.
- State register, squash/drain down-counter (3 bits), halted and redirect_count are registered.
- pc_sel, pc_write and both flush outputs are combinational from state and inputs (Mealy), so they act on the mux in the same cycle.
- Reset (any state, mid-operation included):
  - next state INIT, counter 0, halted 0, redirect_count 0.
  - While rst is high: pc_sel=11, pc_write=0, flush_if_id=1, flush_id_ex=1.
- INIT (exactly one cycle after rst deasserts):
  - pc_sel=11, pc_write=0, no flushes; inputs ignored; go to RUN.
- Define redir = branch_taken | jump.
- RUN priority: redir > halt > stall > sequential.
  - redir:
    - pc_sel=10, pc_write=1, flush_if_id=1, flush_id_ex=1.
    - redirect_count increments, holding at all-ones.
    - If FLUSH_CYCLES=1 stay in RUN; otherwise counter=FLUSH_CYCLES-1 and go to SQUASH.
  - halt (no redir): pc_sel=11, pc_write=0, flush_if_id=1; counter=DRAIN_CYCLES; go to DRAIN.
  - stall (no redir, no halt): pc_sel=11, pc_write=0, no flushes.
  - otherwise: pc_sel = is_compressed ? 01 : 00; pc_write=1.
- SQUASH:
  - branch_taken, jump, halt and stall are all masked, because the instructions they come from are squashed bubbles.
  - Outputs: pc_sel = is_compressed ? 01 : 00, pc_write=1, flush_id_ex=1, flush_if_id=0.
  - Counter decrements each cycle; when it reaches 0, go to RUN.
- DRAIN:
  - Outputs: pc_sel=11, pc_write=0, flush_if_id=1; stall and halt ignored.
  - redir (an older branch/jump) cancels the halt: same outputs and transition as redir in RUN, counter reloaded per FLUSH_CYCLES.
  - Otherwise the counter decrements; when it hits 0, go to HALTED and halted=1 from the next cycle.
- HALTED:
  - pc_sel=11, pc_write=0, no flushes, halted=1; all inputs ignored.
  - Only rst exits this state.
- Simultaneous branch_taken and jump count as one redirect (+1 on redirect_count).
- Out-of-range parameters are a synthesis-time error (generate-time check).

Test Plan:
- Reset/INIT: hold rst 2 cycles, then release with all inputs 0 → INIT cycle shows pc_sel=11, pc_write=0; following cycles show pc_sel=00, pc_write=1; halted=0, redirect_count=0.
- Compressed sequencing: is_compressed pattern 1,0,1 in RUN → pc_sel 01,00,01 with pc_write=1 throughout.
- Redirect, FLUSH_CYCLES=2: branch_taken pulse in RUN →
  - cycle 0: pc_sel=10, both flushes=1.
  - cycle 1: flush_id_ex=1 only; a jump pulse in this cycle is ignored.
  - cycle 2: RUN.
  - redirect_count=1.
- Stall vs redirect: stall=1 and jump=1 together → pc_sel=10, pc_write=1; stall alone → pc_sel=11, pc_write=0 for each stalled cycle.
- Halt drain, DRAIN_CYCLES=3: halt pulse → 3 cycles of pc_sel=11 with flush_if_id=1, then halted=1 permanently; branch_taken during HALTED has no effect; rst returns to INIT with halted=0.
- Halt cancelled plus saturation:
  - branch_taken in the 2nd DRAIN cycle → pc_sel=10 and RUN resumes after squash, halted stays 0.
  - With CNT_W=2, 5 redirects → redirect_count=3.
